keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and optional auto-repeat
//
// Drives one active-low row at a time and watches the active-low columns. A key
// is captured when exactly one column is low. It is accepted after
// debounce_ticks matching scan ticks, and released after debounce_ticks ticks
// with its column high.
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   col[3:0]     column inputs, active-low, asynchronous to clk
//   row[3:0]     row drive, active-low, exactly one bit low
//   key_code     last accepted key {row_idx, col_idx}
//   key_valid    one-cycle pulse on accept (and on repeat)
//   key_pressed  high while an accepted key is held
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to add auto-repeat pulses while
// a key is held.
module keypad_scanner #(
  parameter int scan_speed     = 20,
  parameter int debounce_ticks = 4,
  parameter int repeat_delay   = 64,
  parameter int repeat_rate    = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  localparam logic [3:0] DB_LAST = 4'(debounce_ticks);

  if (debounce_ticks < 1 || debounce_ticks > 15) begin : g_bad_debounce
    $error("keypad_scanner: debounce_ticks must be 1..15");
  end
  if (repeat_delay < 1 || repeat_rate < 1) begin : g_bad_repeat
    $error("keypad_scanner: repeat_delay and repeat_rate must be >= 1");
  end

  logic [3:0]            col_m_q, col_m_d;
  logic [3:0]            col_s_q, col_s_d;
  logic [scan_speed-1:0] presc_q, presc_d;
  logic [1:0]            state_q, state_d;
  logic [1:0]            row_idx_q, row_idx_d;
  logic [1:0]            col_idx_q, col_idx_d;
  logic [3:0]            db_cnt_q, db_cnt_d;
  logic [3:0]            key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;

  logic       tick;
  logic       one_low;
  logic [1:0] low_idx;
  logic [3:0] cap_pat;
  logic       cap_high;
  logic [3:0] db_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [15:0] REP_DELAY = 16'(repeat_delay);
  localparam logic [15:0] REP_RATE  = 16'(repeat_rate);

  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic        rep_first_q, rep_first_d;
  logic [15:0] rep_inc;
  assign rep_inc = rep_cnt_q + 16'd1;
`endif

  assign tick     = &presc_q;
  assign cap_pat  = ~(4'b0001 << col_idx_q);
  assign cap_high = col_s_q[col_idx_q];
  assign db_inc   = db_cnt_q + 4'd1;

  // Anything other than a single low column (none, or ghosting) is not a key.
  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (col_s_q)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    col_m_d     = col;
    col_s_d     = col_m_q;
    presc_d     = presc_q + scan_speed'(1);
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    col_idx_d   = col_idx_q;
    db_cnt_d    = db_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
`endif
    if (tick) begin
      case (state_q)
        S_SCAN: begin
          if (one_low) begin
            col_idx_d = low_idx;
            db_cnt_d  = 4'd0;
            state_d   = S_DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (col_s_q == cap_pat) begin
            db_cnt_d = db_inc;
            if (db_inc == DB_LAST) begin
              state_d     = S_HELD;
              key_code_d  = {row_idx_q, col_idx_q};
              key_valid_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_d   = 16'd0;
              rep_first_d = 1'b1;
`endif
            end
          end else begin
            state_d   = S_SCAN;
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        S_HELD: begin
          if (cap_high) begin
            db_cnt_d = 4'd0;
            state_d  = S_RELEASE;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          // First repeat waits repeat_delay ticks, later ones repeat_rate.
          else if (rep_inc == (rep_first_q ? REP_DELAY : REP_RATE)) begin
            key_valid_d = 1'b1;
            rep_cnt_d   = 16'd0;
            rep_first_d = 1'b0;
          end else begin
            rep_cnt_d = rep_inc;
          end
`endif
        end
        default: begin  // S_RELEASE; repeat counter stays frozen here
          if (cap_high) begin
            db_cnt_d = db_inc;
            if (db_inc == DB_LAST) begin
              state_d   = S_SCAN;
              row_idx_d = row_idx_q + 2'd1;
            end
          end else begin
            state_d = S_HELD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_m_q     <= 4'b1111;
      col_s_q     <= 4'b1111;
      presc_q     <= '0;
      state_q     <= S_SCAN;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      db_cnt_q    <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= 16'd0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      col_m_q     <= col_m_d;
      col_s_q     <= col_s_d;
      presc_q     <= presc_d;
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      db_cnt_q    <= db_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign row         = ~(4'b0001 << row_idx_q);
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = (state_q == S_HELD) || (state_q == S_RELEASE);

endmodule
